// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
// Arbitrates icache/dcache read requests onto one downstream read channel
// (one transaction outstanding, round-robin on ties) and holds one dcache
// write in a single-entry write buffer. A read whose 16-byte line matches
// the buffered (or same-cycle incoming) write is held off until that write
// has been committed downstream.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   s_rd_req/type/addr/rdy     upstream read request side (bit0 icache, bit1 dcache)
//   s_ret_valid/last/data      upstream read return (valid only toward owner)
//   s_wr_req/type/addr/wstrb/data/rdy  upstream dcache write side
//   m_rd_req/type/addr/rdy     downstream read request
//   m_ret_valid/last/data      downstream read return
//   m_wr_req/type/addr/wstrb/data/rdy/done  downstream write side
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          s_rd_req,
    input  logic [5:0]          s_rd_type,
    input  logic [2*ADDR_W-1:0] s_rd_addr,
    output logic [1:0]          s_rd_rdy,
    output logic [1:0]          s_ret_valid,
    output logic                s_ret_last,
    output logic [31:0]         s_ret_data,
    input  logic                s_wr_req,
    input  logic [2:0]          s_wr_type,
    input  logic [ADDR_W-1:0]   s_wr_addr,
    input  logic [3:0]          s_wr_wstrb,
    input  logic [LINE_W-1:0]   s_wr_data,
    output logic                s_wr_rdy,
    output logic                m_rd_req,
    output logic [2:0]          m_rd_type,
    output logic [ADDR_W-1:0]   m_rd_addr,
    input  logic                m_rd_rdy,
    input  logic                m_ret_valid,
    input  logic                m_ret_last,
    input  logic [31:0]         m_ret_data,
    output logic                m_wr_req,
    output logic [2:0]          m_wr_type,
    output logic [ADDR_W-1:0]   m_wr_addr,
    output logic [3:0]          m_wr_wstrb,
    output logic [LINE_W-1:0]   m_wr_data,
    input  logic                m_wr_rdy,
    input  logic                m_wr_done
);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_REQ   = 2'd1;
    localparam logic [1:0] R_RESP  = 2'd2;
    localparam logic [1:0] W_EMPTY = 2'd0;
    localparam logic [1:0] W_REQ   = 2'd1;
    localparam logic [1:0] W_WAIT  = 2'd2;
    localparam logic       REQ_I   = 1'b0;
    localparam logic       REQ_D   = 1'b1;

    logic [1:0]        rd_state_r;
    logic              rr_last_r;
    logic              owner_r;
    logic [2:0]        rd_type_r;
    logic [ADDR_W-1:0] rd_addr_r;

    logic [1:0]        wr_state_r;
    logic              wbuf_valid_r;
    logic [2:0]        wbuf_type_r;
    logic [ADDR_W-1:0] wbuf_addr_r;
    logic [3:0]        wbuf_wstrb_r;
    logic [LINE_W-1:0] wbuf_data_r;

    logic [ADDR_W-1:0] req_addr_s [2];
    logic [2:0]        req_type_s [2];
    logic              wr_fire_s;
    logic [1:0]        hazard_s;
    logic [1:0]        elig_s;
    logic              grant_s;
    logic              winner_s;

    assign req_addr_s[0] = s_rd_addr[ADDR_W-1:0];
    assign req_addr_s[1] = s_rd_addr[2*ADDR_W-1:ADDR_W];
    assign req_type_s[0] = s_rd_type[2:0];
    assign req_type_s[1] = s_rd_type[5:3];

    assign wr_fire_s  = s_wr_req && s_wr_rdy;
    assign elig_s     = s_rd_req & ~hazard_s;
    assign s_ret_last = m_ret_last;
    assign s_ret_data = m_ret_data;
    assign m_rd_type  = rd_type_r;
    assign m_rd_addr  = rd_addr_r;
    assign m_wr_type  = wbuf_type_r;
    assign m_wr_addr  = wbuf_addr_r;
    assign m_wr_wstrb = wbuf_wstrb_r;
    assign m_wr_data  = wbuf_data_r;

    // Line hazard: compare each requester against the buffered write and against a write entering this cycle
    always_comb begin
        hazard_s = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (wbuf_valid_r && (req_addr_s[k][ADDR_W-1:4] == wbuf_addr_r[ADDR_W-1:4])) begin
                hazard_s[k] = 1'b1;
            end else if (wr_fire_s && (req_addr_s[k][ADDR_W-1:4] == s_wr_addr[ADDR_W-1:4])) begin
                hazard_s[k] = 1'b1;
            end else begin
                hazard_s[k] = 1'b0;
            end
        end
    end

    // Grant selection in R_IDLE: on a tie the requester not served last wins
    always_comb begin
        grant_s  = 1'b0;
        winner_s = REQ_D;
        if (reset || (rd_state_r != R_IDLE)) begin
            grant_s = 1'b0;
        end else if (elig_s == 2'b11) begin
            grant_s  = 1'b1;
            winner_s = ~rr_last_r;
        end else if (elig_s[1]) begin
            grant_s  = 1'b1;
            winner_s = REQ_D;
        end else if (elig_s[0]) begin
            grant_s  = 1'b1;
            winner_s = REQ_I;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Handshake/valid outputs, all forced low while reset is asserted
    always_comb begin
        s_rd_rdy    = 2'b00;
        s_ret_valid = 2'b00;
        s_wr_rdy    = 1'b0;
        m_rd_req    = 1'b0;
        m_wr_req    = 1'b0;
        if (!reset) begin
            s_rd_rdy = grant_s ? (winner_s ? 2'b10 : 2'b01) : 2'b00;
            s_wr_rdy = (wr_state_r == W_EMPTY);
            m_rd_req = (rd_state_r == R_REQ);
            m_wr_req = (wr_state_r == W_REQ);
            if ((rd_state_r == R_RESP) && m_ret_valid) begin
                s_ret_valid = owner_r ? 2'b10 : 2'b01;
            end else begin
                s_ret_valid = 2'b00;
            end
        end else begin
            s_rd_rdy = 2'b00;
        end
    end

    // Read FSM: latch the granted request, issue it downstream, pass the return through to the owner
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_r <= R_IDLE;
            rr_last_r  <= REQ_I;
            owner_r    <= REQ_I;
            rd_type_r  <= 3'b000;
            rd_addr_r  <= {ADDR_W{1'b0}};
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (grant_s) begin
                        owner_r    <= winner_s;
                        rr_last_r  <= winner_s;
                        rd_type_r  <= req_type_s[winner_s];
                        rd_addr_r  <= req_addr_s[winner_s];
                        rd_state_r <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (m_rd_rdy) begin
                        rd_state_r <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (m_ret_valid && m_ret_last) begin
                        rd_state_r <= R_IDLE;
                    end
                end
                default: rd_state_r <= R_IDLE;
            endcase
        end
    end

    // Write FSM: single-entry buffer held until the downstream write response
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_r   <= W_EMPTY;
            wbuf_valid_r <= 1'b0;
            wbuf_type_r  <= 3'b000;
            wbuf_addr_r  <= {ADDR_W{1'b0}};
            wbuf_wstrb_r <= 4'b0000;
            wbuf_data_r  <= {LINE_W{1'b0}};
        end else begin
            case (wr_state_r)
                W_EMPTY: begin
                    if (wr_fire_s) begin
                        wbuf_valid_r <= 1'b1;
                        wbuf_type_r  <= s_wr_type;
                        wbuf_addr_r  <= s_wr_addr;
                        wbuf_wstrb_r <= s_wr_wstrb;
                        wbuf_data_r  <= s_wr_data;
                        wr_state_r   <= W_REQ;
                    end
                end
                W_REQ: begin
                    // A response is only meaningful once the write has been accepted
                    if (m_wr_rdy && m_wr_done) begin
                        wbuf_valid_r <= 1'b0;
                        wr_state_r   <= W_EMPTY;
                    end else if (m_wr_rdy) begin
                        wr_state_r <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (m_wr_done) begin
                        wbuf_valid_r <= 1'b0;
                        wr_state_r   <= W_EMPTY;
                    end
                end
                default: begin
                    wbuf_valid_r <= 1'b0;
                    wr_state_r   <= W_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: a table of per-cycle vectors,
// hand-written multi-cycle sequences, and a randomized run against a
// transaction-level reference model.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   s_rd_req;
    logic [5:0]   s_rd_type;
    logic [63:0]  s_rd_addr;
    logic [1:0]   s_rd_rdy;
    logic [1:0]   s_ret_valid;
    logic         s_ret_last;
    logic [31:0]  s_ret_data;
    logic         s_wr_req;
    logic [2:0]   s_wr_type;
    logic [31:0]  s_wr_addr;
    logic [3:0]   s_wr_wstrb;
    logic [127:0] s_wr_data;
    logic         s_wr_rdy;
    logic         m_rd_req;
    logic [2:0]   m_rd_type;
    logic [31:0]  m_rd_addr;
    logic         m_rd_rdy;
    logic         m_ret_valid;
    logic         m_ret_last;
    logic [31:0]  m_ret_data;
    logic         m_wr_req;
    logic [2:0]   m_wr_type;
    logic [31:0]  m_wr_addr;
    logic [3:0]   m_wr_wstrb;
    logic [127:0] m_wr_data;
    logic         m_wr_rdy;
    logic         m_wr_done;

    int n_vec = 0;
    int n_err = 0;

    cache_mem_arbiter #(.LINE_W(128), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .s_rd_req(s_rd_req), .s_rd_type(s_rd_type), .s_rd_addr(s_rd_addr), .s_rd_rdy(s_rd_rdy),
        .s_ret_valid(s_ret_valid), .s_ret_last(s_ret_last), .s_ret_data(s_ret_data),
        .s_wr_req(s_wr_req), .s_wr_type(s_wr_type), .s_wr_addr(s_wr_addr),
        .s_wr_wstrb(s_wr_wstrb), .s_wr_data(s_wr_data), .s_wr_rdy(s_wr_rdy),
        .m_rd_req(m_rd_req), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr), .m_rd_rdy(m_rd_rdy),
        .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last), .m_ret_data(m_ret_data),
        .m_wr_req(m_wr_req), .m_wr_type(m_wr_type), .m_wr_addr(m_wr_addr),
        .m_wr_wstrb(m_wr_wstrb), .m_wr_data(m_wr_data), .m_wr_rdy(m_wr_rdy), .m_wr_done(m_wr_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_vec=%0d n_err=%0d", n_vec, n_err);
        $fatal(1);
    end

    typedef struct {
        bit          rst;
        logic [1:0]  req;
        bit          mrdy;
        bit          rv;
        bit          rl;
        logic [1:0]  e_rdy;
        bit          e_mreq;
        logic [31:0] e_addr;
        logic [1:0]  e_ret;
        bit          e_last;
        bit          e_wrdy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic row(input bit rst, input logic [1:0] req, input bit mrdy, input bit rv, input bit rl,
                       input logic [1:0] e_rdy, input bit e_mreq, input logic [31:0] e_addr,
                       input logic [1:0] e_ret, input bit e_last, input bit e_wrdy);
        vec_t v;
        v.rst = rst; v.req = req; v.mrdy = mrdy; v.rv = rv; v.rl = rl;
        v.e_rdy = e_rdy; v.e_mreq = e_mreq; v.e_addr = e_addr;
        v.e_ret = e_ret; v.e_last = e_last; v.e_wrdy = e_wrdy;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic serve_read(input logic [1:0] own, input int beats, input string tag);
        m_rd_rdy = 1'b1;
        @(negedge clk);
        chk({tag, " m_rd_req"}, 128'(m_rd_req), 128'(1'b1));
        chk({tag, " rdy while busy"}, 128'(s_rd_rdy), 128'(2'b00));
        step();
        m_rd_rdy = 1'b0;
        for (int b = 0; b < beats; b++) begin
            m_ret_valid = 1'b1;
            m_ret_last  = (b == beats - 1);
            m_ret_data  = 32'hA5A5_0000 + 32'(b);
            @(negedge clk);
            chk({tag, " ret_valid"}, 128'(s_ret_valid), 128'(own));
            step();
        end
        m_ret_valid = 1'b0;
        m_ret_last  = 1'b0;
    endtask

    task automatic wait_grant(output logic [1:0] g);
        g = 2'b00;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s_rd_rdy != 2'b00) begin
                g = s_rd_rdy;
                break;
            end
            step();
        end
    endtask

    // reference model state (transaction level)
    logic [1:0]   mreq_pend;
    logic [31:0]  maddr [2];
    logic [2:0]   mtype [2];
    bit           rd_busy, rd_sent;
    int           owner, rr_last, beats_left;
    logic [31:0]  rd_a;
    logic [2:0]   rd_t;
    bit           wb_full, wb_sent;
    logic [31:0]  wb_a;
    logic [2:0]   wb_t;
    logic [3:0]   wb_s;
    logic [127:0] wb_d;

    function automatic logic [31:0] rand_addr();
        return 32'h0000_0100 + 32'($urandom_range(0, 3)) * 32'h10 + 32'($urandom_range(0, 3)) * 32'h4;
    endfunction

    initial begin
        logic [1:0]   gr;
        logic [1:0]   exp_g;
        logic [127:0] d3;
        logic [1:0]   hz, elig, exp_rdy, exp_ret;
        bit           wr_fire;
        int           win;

        reset = 1'b1; s_rd_req = 2'b00; s_rd_type = 6'b010_100;
        s_rd_addr = {32'h0000_5000, 32'h1C00_0040};
        s_wr_req = 1'b0; s_wr_type = 3'b000; s_wr_addr = 32'h0; s_wr_wstrb = 4'h0; s_wr_data = 128'h0;
        m_rd_rdy = 1'b0; m_ret_valid = 1'b0; m_ret_last = 1'b0; m_ret_data = 32'h0;
        m_wr_rdy = 1'b0; m_wr_done = 1'b0;
        step(); step();

        // ---------------- table-driven vectors ----------------
        row(1, 2'b01, 0, 0, 0, 2'b00, 0, 32'h0,         2'b00, 0, 0);
        row(0, 2'b01, 0, 0, 0, 2'b01, 0, 32'h0,         2'b00, 0, 1);
        row(0, 2'b00, 0, 0, 0, 2'b00, 1, 32'h1C00_0040, 2'b00, 0, 1);
        row(0, 2'b00, 1, 0, 0, 2'b00, 1, 32'h1C00_0040, 2'b00, 0, 1);
        row(0, 2'b00, 0, 1, 0, 2'b00, 0, 32'h0,         2'b01, 0, 1);
        row(0, 2'b00, 0, 0, 0, 2'b00, 0, 32'h0,         2'b00, 0, 1);
        row(0, 2'b00, 0, 1, 0, 2'b00, 0, 32'h0,         2'b01, 0, 1);
        row(0, 2'b00, 0, 1, 0, 2'b00, 0, 32'h0,         2'b01, 0, 1);
        row(0, 2'b00, 0, 1, 1, 2'b00, 0, 32'h0,         2'b01, 1, 1);
        row(0, 2'b10, 0, 0, 0, 2'b10, 0, 32'h0,         2'b00, 0, 1);
        row(0, 2'b00, 1, 0, 0, 2'b00, 1, 32'h0000_5000, 2'b00, 0, 1);
        row(0, 2'b00, 0, 1, 0, 2'b00, 0, 32'h0,         2'b10, 0, 1);
        row(0, 2'b00, 0, 1, 0, 2'b00, 0, 32'h0,         2'b10, 0, 1);
        row(1, 2'b00, 0, 1, 0, 2'b00, 0, 32'h0,         2'b00, 0, 0);
        row(0, 2'b11, 0, 0, 0, 2'b10, 0, 32'h0,         2'b00, 0, 1);
        row(0, 2'b00, 0, 0, 0, 2'b00, 1, 32'h0000_5000, 2'b00, 0, 1);
        row(1, 2'b00, 0, 0, 0, 2'b00, 0, 32'h0,         2'b00, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; s_rd_req = tbl[i].req; m_rd_rdy = tbl[i].mrdy;
            m_ret_valid = tbl[i].rv; m_ret_last = tbl[i].rl; m_ret_data = 32'hD000_0000 + 32'(i);
            @(negedge clk);
            chk($sformatf("tbl%0d s_rd_rdy", i), 128'(s_rd_rdy), 128'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d m_rd_req", i), 128'(m_rd_req), 128'(tbl[i].e_mreq));
            chk($sformatf("tbl%0d s_ret_valid", i), 128'(s_ret_valid), 128'(tbl[i].e_ret));
            chk($sformatf("tbl%0d s_wr_rdy", i), 128'(s_wr_rdy), 128'(tbl[i].e_wrdy));
            chk($sformatf("tbl%0d m_wr_req", i), 128'(m_wr_req), 128'(1'b0));
            if (tbl[i].e_mreq)
                chk($sformatf("tbl%0d m_rd_addr", i), 128'(m_rd_addr), 128'(tbl[i].e_addr));
            if (tbl[i].e_ret != 2'b00) begin
                chk($sformatf("tbl%0d s_ret_last", i), 128'(s_ret_last), 128'(tbl[i].e_last));
                chk($sformatf("tbl%0d s_ret_data", i), 128'(s_ret_data), 128'(32'hD000_0000 + 32'(i)));
            end
            step();
        end
        m_rd_rdy = 1'b0; m_ret_valid = 1'b0; m_ret_last = 1'b0;

        // ---------------- fairness: both held from reset ----------------
        s_rd_req = 2'b11; s_rd_type = 6'b100_100; s_rd_addr = {32'h0000_5000, 32'h0000_4000};
        step();
        reset = 1'b0;
        for (int g = 0; g < 4; g++) begin
            exp_g = (g % 2 == 0) ? 2'b10 : 2'b01;
            wait_grant(gr);
            chk($sformatf("fair grant%0d", g), 128'(gr), 128'(exp_g));
            step();
            serve_read(exp_g, 4, "fair");
        end
        s_rd_req = 2'b00;

        // ---------------- victim write blocks same-line dcache read ----------------
        s_wr_req = 1'b1; s_wr_type = 3'b100; s_wr_addr = 32'h0000_1230; s_wr_wstrb = 4'hF;
        s_wr_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        s_rd_req = 2'b10; s_rd_type = 6'b010_100; s_rd_addr = {32'h0000_1234, 32'h0000_4000};
        @(negedge clk);
        chk("victim rdy same cycle", 128'(s_rd_rdy), 128'(2'b00));
        step();
        s_wr_req = 1'b0; m_wr_rdy = 1'b1;
        @(negedge clk);
        chk("victim m_wr_req", 128'(m_wr_req), 128'(1'b1));
        chk("victim m_wr_addr", 128'(m_wr_addr), 128'(32'h0000_1230));
        chk("victim rdy in W_REQ", 128'(s_rd_rdy), 128'(2'b00));
        step();
        m_wr_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("victim rdy in W_WAIT", 128'(s_rd_rdy), 128'(2'b00));
            chk("victim s_wr_rdy", 128'(s_wr_rdy), 128'(1'b0));
            step();
        end
        m_wr_done = 1'b1;
        @(negedge clk);
        chk("victim rdy at done", 128'(s_rd_rdy), 128'(2'b00));
        step();
        m_wr_done = 1'b0;
        @(negedge clk);
        chk("victim rdy after done", 128'(s_rd_rdy), 128'(2'b10));
        chk("victim s_wr_rdy after done", 128'(s_wr_rdy), 128'(1'b1));
        step();
        s_rd_req = 2'b00;
        serve_read(2'b10, 1, "victim");

        // ---------------- same-cycle write vs icache read ----------------
        s_rd_req = 2'b01; s_rd_type = 6'b010_100; s_rd_addr = {32'h0000_9000, 32'h0000_2000};
        s_wr_req = 1'b1; s_wr_type = 3'b010; s_wr_addr = 32'h0000_2008; s_wr_wstrb = 4'h3;
        @(negedge clk);
        chk("samecyc conflict rdy", 128'(s_rd_rdy), 128'(2'b00));
        step();
        s_wr_req = 1'b0; m_wr_rdy = 1'b1;
        @(negedge clk);
        chk("samecyc held W_REQ", 128'(s_rd_rdy), 128'(2'b00));
        step();
        m_wr_rdy = 1'b0; m_wr_done = 1'b1;
        @(negedge clk);
        chk("samecyc held at done", 128'(s_rd_rdy), 128'(2'b00));
        step();
        m_wr_done = 1'b0;
        @(negedge clk);
        chk("samecyc grant after done", 128'(s_rd_rdy), 128'(2'b01));
        step();
        s_rd_req = 2'b00;
        serve_read(2'b01, 4, "samecyc");

        d3 = 128'hCAFE_0000_BEEF_1111_DEAD_2222_F00D_3333;
        s_rd_req = 2'b01;
        s_wr_req = 1'b1; s_wr_type = 3'b100; s_wr_addr = 32'h0000_3000; s_wr_wstrb = 4'hF; s_wr_data = d3;
        @(negedge clk);
        chk("samecyc other line rdy", 128'(s_rd_rdy), 128'(2'b01));
        step();
        s_wr_req = 1'b0; s_rd_req = 2'b00;
        serve_read(2'b01, 4, "samecyc2");

        // ---------------- write stalled by m_wr_rdy, read proceeds ----------------
        s_rd_addr = {32'h0000_7000, 32'h0000_2000};
        for (int i = 0; i < 5; i++) begin
            s_rd_req = (i == 0) ? 2'b10 : 2'b00;
            m_rd_rdy = (i == 1);
            m_ret_valid = (i == 2); m_ret_last = (i == 2);
            @(negedge clk);
            chk($sformatf("stall%0d m_wr_req", i), 128'(m_wr_req), 128'(1'b1));
            chk($sformatf("stall%0d m_wr_addr", i), 128'(m_wr_addr), 128'(32'h0000_3000));
            chk($sformatf("stall%0d m_wr_data", i), m_wr_data, d3);
            chk($sformatf("stall%0d s_wr_rdy", i), 128'(s_wr_rdy), 128'(1'b0));
            if (i == 0) chk("stall grant", 128'(s_rd_rdy), 128'(2'b10));
            if (i == 1) chk("stall m_rd_addr", 128'(m_rd_addr), 128'(32'h0000_7000));
            if (i == 2) chk("stall ret", 128'({s_ret_valid, s_ret_last}), 128'(3'b101));
            if (i >= 3) chk("stall ret idle", 128'(s_ret_valid), 128'(2'b00));
            step();
        end
        m_ret_valid = 1'b0; m_ret_last = 1'b0; m_wr_rdy = 1'b1;
        step();
        m_wr_rdy = 1'b0; m_wr_done = 1'b1;
        step();
        m_wr_done = 1'b0;
        @(negedge clk);
        chk("stall s_wr_rdy end", 128'(s_wr_rdy), 128'(1'b1));
        step();

        // ---------------- randomized run against reference model ----------------
        reset = 1'b1; s_rd_req = 2'b00;
        step(); step();
        reset = 1'b0;
        mreq_pend = 2'b00; rd_busy = 0; rd_sent = 0; owner = 0; rr_last = 0; beats_left = 0;
        wb_full = 0; wb_sent = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                if (!mreq_pend[k] && $urandom_range(0, 2) == 0) begin
                    mreq_pend[k] = 1'b1;
                    maddr[k] = rand_addr();
                    mtype[k] = $urandom_range(0, 1) ? 3'b100 : 3'b010;
                end
            end
            s_rd_req = mreq_pend; s_rd_addr = {maddr[1], maddr[0]}; s_rd_type = {mtype[1], mtype[0]};
            s_wr_req = !wb_full && ($urandom_range(0, 4) == 0);
            s_wr_type = $urandom_range(0, 1) ? 3'b100 : 3'b010;
            s_wr_addr = rand_addr(); s_wr_wstrb = 4'($urandom);
            s_wr_data = {$urandom, $urandom, $urandom, $urandom};
            m_rd_rdy = 1'($urandom_range(0, 1));
            m_ret_valid = 1'($urandom_range(0, 1));
            m_ret_last = (rd_busy && rd_sent) ? (beats_left == 1) : 1'($urandom_range(0, 1));
            m_ret_data = $urandom;
            m_wr_rdy = 1'($urandom_range(0, 1));
            m_wr_done = (wb_full && wb_sent) ? ($urandom_range(0, 2) == 0) : (wb_full && $urandom_range(0, 3) == 0);
            @(negedge clk);
            wr_fire = s_wr_req && !wb_full;
            for (int k = 0; k < 2; k++) begin
                hz[k] = (wb_full && (maddr[k][31:4] == wb_a[31:4])) ||
                        (wr_fire && (maddr[k][31:4] == s_wr_addr[31:4]));
                elig[k] = mreq_pend[k] && !hz[k];
            end
            win = -1;
            if (!rd_busy) begin
                if (elig == 2'b11) win = 1 - rr_last;
                else if (elig[1]) win = 1;
                else if (elig[0]) win = 0;
            end
            exp_rdy = (win < 0) ? 2'b00 : ((win == 1) ? 2'b10 : 2'b01);
            exp_ret = (rd_busy && rd_sent && m_ret_valid) ? ((owner == 1) ? 2'b10 : 2'b01) : 2'b00;
            chk("rnd s_rd_rdy", 128'(s_rd_rdy), 128'(exp_rdy));
            chk("rnd s_wr_rdy", 128'(s_wr_rdy), 128'(!wb_full));
            chk("rnd m_rd_req", 128'(m_rd_req), 128'(rd_busy && !rd_sent));
            chk("rnd s_ret_valid", 128'(s_ret_valid), 128'(exp_ret));
            chk("rnd m_wr_req", 128'(m_wr_req), 128'(wb_full && !wb_sent));
            if (rd_busy && !rd_sent)
                chk("rnd m_rd_addr/type", 128'({m_rd_addr, m_rd_type}), 128'({rd_a, rd_t}));
            if (exp_ret != 2'b00)
                chk("rnd ret last/data", 128'({s_ret_last, s_ret_data}), 128'({m_ret_last, m_ret_data}));
            if (wb_full && !wb_sent)
                chk("rnd m_wr payload", {m_wr_data[127:39], m_wr_addr, m_wr_type, m_wr_wstrb},
                    {wb_d[127:39], wb_a, wb_t, wb_s});
            if (win >= 0) begin
                rd_busy = 1; rd_sent = 0; owner = win; rd_a = maddr[win]; rd_t = mtype[win];
                rr_last = win; mreq_pend[win] = 1'b0;
            end else if (rd_busy && !rd_sent) begin
                if (m_rd_rdy) begin
                    rd_sent = 1;
                    beats_left = (rd_t == 3'b100) ? 4 : 1;
                end
            end else if (rd_busy && rd_sent && m_ret_valid) begin
                beats_left--;
                if (m_ret_last) rd_busy = 0;
            end
            if (wr_fire) begin
                wb_full = 1; wb_sent = 0; wb_a = s_wr_addr; wb_t = s_wr_type; wb_s = s_wr_wstrb; wb_d = s_wr_data;
            end else if (wb_full && !wb_sent) begin
                if (m_wr_rdy) begin
                    if (m_wr_done) wb_full = 0;
                    else wb_sent = 1;
                end
            end else if (wb_full && wb_sent && m_wr_done) begin
                wb_full = 0;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Sits between the instruction cache, the data cache and the single memory-side bridge. It arbitrates the two caches' refill/uncached read requests onto one downstream read channel, with one transaction outstanding. It buffers one data-cache write (victim line or uncached word) in a single-entry write buffer. It blocks any read whose 16-byte line matches the buffered write until that write completes.

Parameters:
LINE_W, 128, write data width in bits (one cache line, 4 words)
ADDR_W, 32, address width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
s_rd_req  in  2  read request; bit0 = icache, bit1 = dcache; held until accepted
s_rd_type  in  6  per-requester type, [2:0] icache, [5:3] dcache; 010 word, 100 line
s_rd_addr  in  2*ADDR_W  per-requester address, [31:0] icache, [63:32] dcache
s_rd_rdy  out  2  accept strobe; a read is accepted when s_rd_req[k] && s_rd_rdy[k]
s_ret_valid  out  2  return beat valid, asserted only toward the owning requester
s_ret_last  out  1  last beat; broadcast, meaningful only with s_ret_valid
s_ret_data  out  32  return data; broadcast
s_wr_req  in  1  dcache write request; single-cycle pulse, legal only while s_wr_rdy=1
s_wr_type  in  3  010 word, 100 line
s_wr_addr  in  ADDR_W  write address
s_wr_wstrb  in  4  byte strobe for word writes
s_wr_data  in  LINE_W  write data; for word writes, the word is in [31:0]
s_wr_rdy  out  1  write buffer empty
m_rd_req  out  1  downstream read request
m_rd_type  out  3  downstream read type
m_rd_addr  out  ADDR_W  downstream read address
m_rd_rdy  in  1  downstream accepts the read when m_rd_req && m_rd_rdy
m_ret_valid  in  1  return beat valid
m_ret_last  in  1  last return beat
m_ret_data  in  32  return beat data
m_wr_req  out  1  downstream write request
m_wr_type  out  3  downstream write type
m_wr_addr  out  ADDR_W  downstream write address
m_wr_wstrb  out  4  downstream write strobe
m_wr_data  out  LINE_W  downstream write data
m_wr_rdy  in  1  downstream accepts the write when m_wr_req && m_wr_rdy
m_wr_done  in  1  single-cycle pulse: write response, data committed

Behaviour:
- Reset: s_rd_rdy=0, s_ret_valid=0, m_rd_req=0, m_wr_req=0, s_wr_rdy=0 during reset and 1 afterward. Read FSM goes to R_IDLE, write FSM to W_EMPTY, rr_last=icache (so the dcache wins the first tie). All address/data registers clear to 0. Reset mid-transaction abandons all state; the downstream side must be reset together with this block.
- Read FSM has three states: R_IDLE, R_REQ and R_RESP.
- R_IDLE, eligibility: requester k is eligible if s_rd_req[k]=1 and hazard[k]=0.
- R_IDLE, hazard: hazard[k]=1 when the write buffer is valid and s_rd_addr_k[31:4] == wbuf_addr[31:4]. hazard[k] is also 1 when s_wr_req fires in the same cycle and s_rd_addr_k[31:4] == s_wr_addr[31:4].
- R_IDLE, grant: if both requesters are eligible, grant the one not equal to rr_last; otherwise grant the single eligible one.
- R_IDLE, on grant: s_rd_rdy[winner]=1 combinationally (one cycle). Latch the winner's type and address and the owner id, set rr_last=winner, go to R_REQ. s_rd_rdy is 0 in all other states.
- R_REQ: m_rd_req=1 with the latched type and address. Hold until m_rd_rdy, then go to R_RESP. Latency from accept to m_rd_req is exactly 1 cycle.
- R_RESP: s_ret_valid[owner]=m_ret_valid, s_ret_valid[other]=0. s_ret_data=m_ret_data and s_ret_last=m_ret_last, combinational pass-through.
- R_RESP exit: on m_ret_valid && m_ret_last, go to R_IDLE. A new grant is possible the following cycle. Line reads return 4 beats and word reads 1 beat; the beat count is not checked.
- Write FSM has three states: W_EMPTY, W_REQ and W_WAIT. s_wr_rdy = (state==W_EMPTY).
- W_EMPTY: on s_wr_req, capture type, addr, wstrb and data into wbuf, set valid, go to W_REQ.
- W_REQ: m_wr_req=1 with wbuf contents. On m_wr_rdy go to W_WAIT.
- W_WAIT: on m_wr_done, clear valid and go to W_EMPTY. s_wr_rdy rises the next cycle.
- A m_wr_done arriving in W_REQ counts only if it coincides with acceptance; otherwise it is ignored.
- Reads and writes proceed concurrently and independently, except for the line hazard.

Test Plan:
- icache line read at 0x1C000040 alone -> s_rd_rdy=01 for 1 cycle. Next cycle m_rd_req=1 with addr 0x1C000040, type 100. 4 beats reach s_ret_valid=01; last beat has s_ret_last=1; FSM returns to R_IDLE.
- Both requesters held continuously from reset, each served with 4-beat returns -> grant order is dcache, icache, dcache, icache. No requester is granted twice in a row while both are pending.
- dcache victim write to 0x00001230 while the dcache read is 0x00001234 -> read is held (s_rd_rdy=00) until m_wr_done. The read is accepted in the first R_IDLE cycle after the buffer empties.
- s_wr_req and the icache read to 0x00002000 in the same cycle (write to 0x00002008) -> icache is not granted until after m_wr_done. A write to 0x00003000 in the same cycle does not block it.
- m_wr_rdy held low for 5 cycles -> m_wr_req held steady with constant addr/data and s_wr_rdy=0. Meanwhile a non-conflicting dcache read completes.
- Reset asserted during R_RESP after beat 2 -> next cycle all outputs are at reset values. After release, a fresh request is granted with dcache priority.
